// File: rtl/alu_rs_pool_pkg.sv
// Shared types for the ALU reservation-station pool.
//   lc3b_opcode : 4-bit LC-3b opcode encoding carried by every RS entry.
//   clog2_min1  : index/pointer width helper that never returns zero.
// The entry and CDB-request records depend on the pool's width parameters,
// so they are declared inside the modules that own those parameters.
package alu_rs_pool_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STB  = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_SHF  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } lc3b_opcode;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu_rs_pool_rr_cdb_arbiter.sv
// Round-robin CDB arbiter.
//   clk, rst_n   : clock, asynchronous active-low reset (pointer -> 0)
//   block_i      : suppress all grants this cycle; pointer holds
//   req_valid_i  : one request bit per requester
//   req_tag_i    : packed tags, requester i at [i*TAG_WIDTH +: TAG_WIDTH]
//   req_data_i   : packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant_o      : one-hot grant (combinational)
//   out_*_o      : winner's valid/tag/data, zero when nothing is granted
module rr_cdb_arbiter
    import alu_rs_pool_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       block_i,
    input  logic [NREQ-1:0]            req_valid_i,
    input  logic [NREQ*TAG_WIDTH-1:0]  req_tag_i,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]            grant_o,
    output logic                       out_valid_o,
    output logic [TAG_WIDTH-1:0]       out_tag_o,
    output logic [DATA_WIDTH-1:0]      out_data_o
);

    localparam int PTR_W = clog2_min1(NREQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win, cand;
    logic             found;

    // Scan requesters starting at the pointer, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(ptr_q) + k >= NREQ) cand = PTR_W'(int'(ptr_q) + k - NREQ);
            else                         cand = PTR_W'(int'(ptr_q) + k);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        grant_o     = '0;
        out_valid_o = 1'b0;
        out_tag_o   = '0;
        out_data_o  = '0;
        ptr_d       = ptr_q;
        if (found && !block_i) begin
            grant_o[win] = 1'b1;
            out_valid_o  = 1'b1;
            out_tag_o    = req_tag_i[win*TAG_WIDTH +: TAG_WIDTH];
            out_data_o   = req_data_i[win*DATA_WIDTH +: DATA_WIDTH];
            ptr_d        = (win == LAST) ? '0 : PTR_W'(win + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/alu_rs_pool.sv
// ALU reservation-station pool with shared ALU and CDB arbitration.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   flush                       : squash entries and held result, block CDB
//   issue_valid / issue_ready   : issue handshake (ready = a free entry)
//   op_in, Vj, Vk, Qj, Qk,
//   qj_pend, qk_pend, dest      : issued instruction and its operand state
//   cdb_in_valid/_tag/_data     : snooped CDB broadcast
//   ext_req/_tag/_data          : external CDB requesters (packed)
//   ext_grant                   : one-hot grant to external requesters
//   cdb_out_valid/_tag/_data    : CDB drive from the arbitration winner
//   busy_out                    : per-entry occupancy
module alu_rs_pool
    import alu_rs_pool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3,
    parameter int N_ENTRIES  = 4,
    parameter int N_EXT      = 1,
    localparam int EXT_W     = (N_EXT > 0) ? N_EXT : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  lc3b_opcode                  op_in,
    input  logic [DATA_WIDTH-1:0]       Vj,
    input  logic [DATA_WIDTH-1:0]       Vk,
    input  logic [TAG_WIDTH-1:0]        Qj,
    input  logic [TAG_WIDTH-1:0]        Qk,
    input  logic                        qj_pend,
    input  logic                        qk_pend,
    input  logic [TAG_WIDTH-1:0]        dest,
    input  logic                        cdb_in_valid,
    input  logic [TAG_WIDTH-1:0]        cdb_in_tag,
    input  logic [DATA_WIDTH-1:0]       cdb_in_data,
    input  logic [EXT_W-1:0]            ext_req,
    input  logic [EXT_W*TAG_WIDTH-1:0]  ext_tag,
    input  logic [EXT_W*DATA_WIDTH-1:0] ext_data,
    output logic [EXT_W-1:0]            ext_grant,
    output logic                        cdb_out_valid,
    output logic [TAG_WIDTH-1:0]        cdb_out_tag,
    output logic [DATA_WIDTH-1:0]       cdb_out_data,
    output logic [N_ENTRIES-1:0]        busy_out
);

    localparam int IDX_W = clog2_min1(N_ENTRIES);
    localparam int AGE_W = clog2_min1(N_ENTRIES);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(N_ENTRIES - 1);
    localparam int NREQ = N_EXT + 1;

    typedef struct packed {
        logic                  busy;
        lc3b_opcode            op;
        logic [DATA_WIDTH-1:0] vj;
        logic [DATA_WIDTH-1:0] vk;
        logic [TAG_WIDTH-1:0]  qj;
        logic [TAG_WIDTH-1:0]  qk;
        logic                  pend_j;
        logic                  pend_k;
        logic [TAG_WIDTH-1:0]  dest;
        logic [AGE_W-1:0]      age;
    } rs_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_req_t;

    function automatic logic [DATA_WIDTH-1:0] alu_f(input lc3b_opcode op,
                                                     input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_AND:  return a & b;
            OP_NOT:  return ~a;
            default: return a;
        endcase
    endfunction

    rs_entry_t rs_q [N_ENTRIES];
    rs_entry_t rs_d [N_ENTRIES];
    cdb_req_t  res_q, res_d;
    rs_entry_t new_entry;

    logic [N_ENTRIES-1:0] ready;
    logic                 sel_found, free_found;
    logic [IDX_W-1:0]     sel_idx, free_idx;
    logic [AGE_W-1:0]     sel_age;
    logic                 accept, dispatch;
    logic                 byp_j, byp_k;

    logic [NREQ-1:0]            req_valid, grant;
    logic [NREQ*TAG_WIDTH-1:0]  req_tag;
    logic [NREQ*DATA_WIDTH-1:0] req_data;
    logic                       arb_block;

    // Readiness and selection use registered state only, so a snoop that
    // wakes an entry makes it eligible on the following cycle.
    always_comb begin
        ready      = '0;
        busy_out   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_age    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            busy_out[i] = rs_q[i].busy;
            ready[i]    = rs_q[i].busy & ~rs_q[i].pend_j & ~rs_q[i].pend_k;
            // strict '>' keeps the lowest index on equal ages
            if (ready[i] && (!sel_found || rs_q[i].age > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = rs_q[i].age;
            end
            if (!rs_q[i].busy && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_ready = free_found;
    assign accept      = issue_valid & free_found & ~flush;
    // The result register may be refilled on the edge it is being granted.
    assign dispatch    = sel_found & (~res_q.valid | grant[0]) & ~flush;

    // Operands whose producer broadcasts in the issue cycle are captured now.
    assign byp_j = qj_pend & cdb_in_valid & (Qj == cdb_in_tag);
    assign byp_k = qk_pend & cdb_in_valid & (Qk == cdb_in_tag);

    always_comb begin
        new_entry        = '0;
        new_entry.busy   = 1'b1;
        new_entry.op     = op_in;
        new_entry.vj     = byp_j ? cdb_in_data : Vj;
        new_entry.vk     = byp_k ? cdb_in_data : Vk;
        new_entry.qj     = Qj;
        new_entry.qk     = Qk;
        new_entry.pend_j = qj_pend & ~byp_j;
        new_entry.pend_k = qk_pend & ~byp_k;
        new_entry.dest   = dest;
        new_entry.age    = '0;
    end

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            rs_d[i] = rs_q[i];
            if (flush) begin
                rs_d[i] = '0;
            end else if (dispatch && sel_idx == IDX_W'(i)) begin
                rs_d[i].busy = 1'b0;
            end else if (accept && free_idx == IDX_W'(i)) begin
                rs_d[i] = new_entry;
            end else if (rs_q[i].busy) begin
                if (cdb_in_valid && rs_q[i].pend_j && rs_q[i].qj == cdb_in_tag) begin
                    rs_d[i].vj     = cdb_in_data;
                    rs_d[i].pend_j = 1'b0;
                end
                if (cdb_in_valid && rs_q[i].pend_k && rs_q[i].qk == cdb_in_tag) begin
                    rs_d[i].vk     = cdb_in_data;
                    rs_d[i].pend_k = 1'b0;
                end
                if (accept && rs_q[i].age < AGE_MAX) rs_d[i].age = rs_q[i].age + 1'b1;
            end
        end
    end

    always_comb begin
        res_d = res_q;
        if (flush) begin
            res_d = '0;
        end else if (dispatch) begin
            res_d.valid = 1'b1;
            res_d.tag   = rs_q[sel_idx].dest;
            res_d.data  = alu_f(rs_q[sel_idx].op, rs_q[sel_idx].vj, rs_q[sel_idx].vk);
        end else if (grant[0]) begin
            res_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) rs_q[i] <= '0;
            res_q <= '0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) rs_q[i] <= rs_d[i];
            res_q <= res_d;
        end
    end

    // Requester 0 is the held ALU result; externals follow in order.
    assign req_valid[0]              = res_q.valid;
    assign req_tag[TAG_WIDTH-1:0]    = res_q.tag;
    assign req_data[DATA_WIDTH-1:0]  = res_q.data;

    generate
        if (N_EXT > 0) begin : g_ext
            assign req_valid[NREQ-1:1]                    = ext_req;
            assign req_tag[NREQ*TAG_WIDTH-1:TAG_WIDTH]    = ext_tag;
            assign req_data[NREQ*DATA_WIDTH-1:DATA_WIDTH] = ext_data;
            assign ext_grant                              = grant[NREQ-1:1];
        end else begin : g_no_ext
            assign ext_grant = '0;
        end
    endgenerate

    // Grants are withheld while flushing and while reset is asserted, so the
    // CDB is quiet even if an external requester keeps its request up.
    assign arb_block = flush | ~rst_n;

    rr_cdb_arbiter #(
        .NREQ       (NREQ),
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .block_i     (arb_block),
        .req_valid_i (req_valid),
        .req_tag_i   (req_tag),
        .req_data_i  (req_data),
        .grant_o     (grant),
        .out_valid_o (cdb_out_valid),
        .out_tag_o   (cdb_out_tag),
        .out_data_o  (cdb_out_data)
    );

endmodule

// File: tb/tb_alu_rs_pool.sv
// Self-checking bench for alu_rs_pool: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_alu_rs_pool;
    import alu_rs_pool_pkg::*;

    localparam int DW = 16;
    localparam int TW = 3;
    localparam int N  = 4;
    localparam int NE = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, flush, issue_valid, issue_ready;
    lc3b_opcode      op_in;
    logic [DW-1:0]   Vj, Vk, cdb_in_data, ext_data, cdb_out_data;
    logic [TW-1:0]   Qj, Qk, dest, cdb_in_tag, ext_tag, cdb_out_tag;
    logic            qj_pend, qk_pend, cdb_in_valid, cdb_out_valid;
    logic [NE-1:0]   ext_req, ext_grant;
    logic [N-1:0]    busy_out;

    alu_rs_pool #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .N_ENTRIES(N), .N_EXT(NE)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .op_in(op_in),
        .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk), .qj_pend(qj_pend), .qk_pend(qk_pend),
        .dest(dest), .cdb_in_valid(cdb_in_valid), .cdb_in_tag(cdb_in_tag),
        .cdb_in_data(cdb_in_data), .ext_req(ext_req), .ext_tag(ext_tag),
        .ext_data(ext_data), .ext_grant(ext_grant), .cdb_out_valid(cdb_out_valid),
        .cdb_out_tag(cdb_out_tag), .cdb_out_data(cdb_out_data), .busy_out(busy_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: each slot remembers the issue number it was written
    // at; age is the count of later accepted issues, capped at N-1.
    bit            m_busy [N];
    lc3b_opcode    m_op   [N];
    logic [DW-1:0] m_a [N], m_b [N];
    logic [TW-1:0] m_qa [N], m_qb [N], m_dest [N];
    bit            m_pa [N], m_pb [N];
    int            m_seq [N];
    int            m_cnt;
    bit            m_rv;
    logic [TW-1:0] m_rt;
    logic [DW-1:0] m_rd;
    int            m_ptr;

    int            m_sel, m_win, m_free;
    bit            m_disp, m_acc, ext_drop;
    logic          e_valid, e_ready;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_data;
    logic [NE-1:0] e_grant;
    logic [N-1:0]  e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int age_of(input int i);
        int a;
        a = m_cnt - m_seq[i];
        return (a > N - 1) ? N - 1 : a;
    endfunction

    function automatic logic [DW-1:0] alu_ref(input lc3b_opcode op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_AND:  return a & b;
            OP_NOT:  return ~a;
            default: return a;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_pa[i] = 0; m_pb[i] = 0; m_seq[i] = 0;
        end
        m_cnt = 0; m_rv = 0; m_rt = '0; m_rd = '0; m_ptr = 0;
    endtask

    task automatic eval();
        bit req [NE+1];
        m_sel = -1;
        for (int i = 0; i < N; i++)
            if (m_busy[i] && !m_pa[i] && !m_pb[i] && (m_sel < 0 || age_of(i) > age_of(m_sel)))
                m_sel = i;
        req[0] = m_rv;
        for (int j = 0; j < NE; j++) req[j+1] = ext_req[j];
        m_win = -1;
        for (int k = 0; k <= NE; k++)
            if (m_win < 0 && req[(m_ptr + k) % (NE + 1)]) m_win = (m_ptr + k) % (NE + 1);
        if (flush) m_win = -1;
        e_valid = (m_win >= 0);
        e_tag   = (m_win == 0) ? m_rt : (m_win > 0) ? ext_tag : '0;
        e_data  = (m_win == 0) ? m_rd : (m_win > 0) ? ext_data : '0;
        e_grant = (m_win == 1) ? 1'b1 : 1'b0;
        m_free = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) m_free = i;
        e_ready = (m_free >= 0);
        for (int i = 0; i < N; i++) e_busy[i] = m_busy[i];
        m_disp = (m_sel >= 0) && (!m_rv || m_win == 0) && !flush;
        m_acc  = issue_valid && e_ready && !flush;
    endtask

    task automatic commit();
        eval();
        ext_drop = (m_win == 1);
        if (flush) begin
            for (int i = 0; i < N; i++) m_busy[i] = 0;
            m_rv = 0;
            return;
        end
        if (m_win >= 0) m_ptr = (m_win + 1) % (NE + 1);
        if (m_disp) begin
            m_rv = 1; m_rt = m_dest[m_sel];
            m_rd = alu_ref(m_op[m_sel], m_a[m_sel], m_b[m_sel]);
            m_busy[m_sel] = 0;
        end else if (m_win == 0) begin
            m_rv = 0;
        end
        if (cdb_in_valid)
            for (int i = 0; i < N; i++) if (m_busy[i]) begin
                if (m_pa[i] && m_qa[i] == cdb_in_tag) begin m_a[i] = cdb_in_data; m_pa[i] = 0; end
                if (m_pb[i] && m_qb[i] == cdb_in_tag) begin m_b[i] = cdb_in_data; m_pb[i] = 0; end
            end
        if (m_acc) begin
            m_cnt++;
            m_busy[m_free] = 1; m_seq[m_free] = m_cnt; m_op[m_free] = op_in;
            m_dest[m_free] = dest; m_qa[m_free] = Qj; m_qb[m_free] = Qk;
            m_pa[m_free] = qj_pend && !(cdb_in_valid && Qj == cdb_in_tag);
            m_pb[m_free] = qk_pend && !(cdb_in_valid && Qk == cdb_in_tag);
            m_a[m_free]  = (qj_pend && !m_pa[m_free]) ? cdb_in_data : Vj;
            m_b[m_free]  = (qk_pend && !m_pb[m_free]) ? cdb_in_data : Vk;
        end
    endtask

    // The compare point for every clocked cycle: 1 time unit after negedge.
    task automatic settle();
        #1;
        eval();
        chk("busy_out", busy_out, e_busy);
        chk("issue_ready", issue_ready, e_ready);
        chk("cdb_out_valid", cdb_out_valid, e_valid);
        chk("cdb_out_tag", cdb_out_tag, e_tag);
        chk("cdb_out_data", cdb_out_data, e_data);
        chk("ext_grant", ext_grant, e_grant);
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        @(negedge clk);
        if (ext_drop) ext_req = '0;
        ext_drop = 0;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        flush = 0; issue_valid = 0; op_in = OP_BR; Vj = '0; Vk = '0; Qj = '0; Qk = '0;
        qj_pend = 0; qk_pend = 0; dest = '0;
        cdb_in_valid = 0; cdb_in_tag = '0; cdb_in_data = '0;
    endtask

    task automatic set_issue(input lc3b_opcode op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic pj, input logic [TW-1:0] qa, input logic pk,
                             input logic [TW-1:0] qb, input logic [TW-1:0] d);
        issue_valid = 1; op_in = op; Vj = a; Vk = b;
        qj_pend = pj; Qj = qa; qk_pend = pk; Qk = qb; dest = d;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_ready"}, issue_ready, 1);
        chk({tag, "_valid"}, cdb_out_valid, 0);
        chk({tag, "_tag"}, cdb_out_tag, 0);
        chk({tag, "_data"}, cdb_out_data, 0);
        chk({tag, "_grant"}, ext_grant, 0);
    endtask

    // Called at a negedge; asserts reset mid-cycle and releases it at a later negedge.
    task automatic async_reset(input string tag);
        #2 rst_n = 0;
        #1 reset_checks(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int alu_g, ext_g;
        rst_n = 0; ext_req = '0; ext_tag = '0; ext_data = '0; ext_drop = 0;
        idle();
        #3 reset_checks("por");
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // ADD 5+3 -> tag 2 data 8 on the CDB two cycles after the issue edge
        set_issue(OP_ADD, 16'h0005, 16'h0003, 0, 0, 0, 0, 3'd2); step();
        idle(); step();
        settle();
        chk("t1_valid", cdb_out_valid, 1); chk("t1_tag", cdb_out_tag, 2); chk("t1_data", cdb_out_data, 16'h0008);
        tick();

        // AND waits on tag 5; no CDB output until the snoop
        set_issue(OP_AND, 16'h0000, 16'h0FF0, 1, 3'd5, 0, 0, 3'd3); step();
        idle();
        for (int c = 0; c < 3; c++) begin settle(); chk("t2_nodisp", cdb_out_valid, 0); tick(); end
        cdb_in_valid = 1; cdb_in_tag = 3'd5; cdb_in_data = 16'h00F0; step();
        idle(); step();
        settle();
        chk("t2_valid", cdb_out_valid, 1); chk("t2_tag", cdb_out_tag, 3); chk("t2_data", cdb_out_data, 16'h00F0);
        tick();

        // Same-cycle bypass of Vk
        set_issue(OP_ADD, 16'h0001, 16'h0000, 0, 0, 1, 3'd4, 3'd6);
        cdb_in_valid = 1; cdb_in_tag = 3'd4; cdb_in_data = 16'hAAAA; step();
        idle(); step();
        settle();
        chk("t5_tag", cdb_out_tag, 6); chk("t5_data", cdb_out_data, 16'hAAAB);
        tick();

        // Fill all entries pending; wake 1 and 3 together; older (1) first
        idle(); flush = 1; step(); flush = 0;
        for (int i = 0; i < N; i++) begin
            set_issue(OP_ADD, 16'(i), 16'h0010, 1, (i % 2) ? 3'd7 : 3'd6, 0, 0, 3'(4 + i));
            step();
        end
        set_issue(OP_NOT, 16'h1111, 0, 0, 0, 0, 0, 3'd1);
        settle(); chk("t3_full_ready", issue_ready, 0); chk("t3_full_busy", busy_out, 4'hF);
        tick();
        idle(); cdb_in_valid = 1; cdb_in_tag = 3'd7; cdb_in_data = 16'h0020; step();
        idle(); step();
        settle(); chk("t3_first_tag", cdb_out_tag, 5); chk("t3_first_data", cdb_out_data, 16'h0030);
        tick();
        settle(); chk("t3_second_tag", cdb_out_tag, 7);
        tick();
        flush = 1; step(); flush = 0;

        // ALU results competing with an external requester
        set_issue(OP_ADD, 16'h0100, 16'h0001, 0, 0, 0, 0, 3'd1); step();
        set_issue(OP_ADD, 16'h0200, 16'h0001, 0, 0, 0, 0, 3'd3); step();
        idle(); ext_req = 1'b1; ext_tag = 3'd6; ext_data = 16'h1234;
        alu_g = 0; ext_g = 0;
        for (int c = 0; c < 5; c++) begin
            settle();
            if (ext_grant[0]) begin
                ext_g++;
                chk("t4_ext_tag", cdb_out_tag, 6); chk("t4_ext_data", cdb_out_data, 16'h1234);
            end else if (cdb_out_valid) alu_g++;
            tick();
        end
        chk("t4_ext_grants", ext_g, 1); chk("t4_alu_grants", alu_g, 2);

        // Flush with three busy entries and a held result
        idle(); flush = 1; step(); flush = 0;
        for (int i = 0; i < 3; i++) begin set_issue(OP_ADD, 0, 0, 1, 3'd7, 0, 0, 3'd0); step(); end
        set_issue(OP_ADD, 16'h0002, 16'h0002, 0, 0, 0, 0, 3'd2); step();
        idle(); step();
        flush = 1;
        settle(); chk("t6_flush_valid", cdb_out_valid, 0); chk("t6_flush_busy", busy_out, 4'h7);
        chk("t6_flush_grant", ext_grant, 0);
        tick();
        flush = 0;
        settle(); chk("t6_after_busy", busy_out, 0); chk("t6_after_valid", cdb_out_valid, 0);
        tick();

        // Reset while an entry is dispatching
        set_issue(OP_ADD, 16'h0007, 16'h0001, 0, 0, 0, 0, 3'd5); step();
        idle();
        async_reset("t7");

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 399) == 0) begin
                async_reset("rnd_rst");
                continue;
            end
            flush        = ($urandom_range(0, 63) == 0);
            issue_valid  = $urandom_range(0, 1);
            op_in        = lc3b_opcode'(4'($urandom_range(0, 15)));
            Vj           = 16'($urandom);
            Vk           = 16'($urandom);
            Qj           = 3'($urandom_range(0, 7));
            Qk           = 3'($urandom_range(0, 7));
            qj_pend      = ($urandom_range(0, 2) == 0);
            qk_pend      = ($urandom_range(0, 2) == 0);
            dest         = 3'($urandom_range(0, 7));
            cdb_in_valid = $urandom_range(0, 1);
            cdb_in_tag   = 3'($urandom_range(0, 7));
            cdb_in_data  = 16'($urandom);
            if (!ext_req[0] && $urandom_range(0, 2) == 0) begin
                ext_req = 1'b1; ext_tag = 3'($urandom_range(0, 7)); ext_data = 16'($urandom);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_rs_pool.md
Name: alu_rs_pool

Overview:
Parametrised ALU reservation-station pool: the next generation of the ALU RS unit. It has N entries with internal free-slot allocation, CDB operand snooping, and oldest-ready dispatch into one shared ALU. A held ALU result register feeds a round-robin CDB arbiter that also serves N_EXT external requesters, such as the load buffer. It sits between the issue stage and the common data bus.

Parameters:
DATA_WIDTH, 16, operand/result width
TAG_WIDTH, 3, ROB/RS tag width
N_ENTRIES, 4, reservation-station entries (>=2)
N_EXT, 1, external CDB requesters (>=0)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all state except arbiter pointer
issue_valid  in  1  issue request this cycle
issue_ready  out  1  at least one free entry
op_in  in  lc3b_opcode  operation
Vj, Vk  in  DATA_WIDTH  operand values; Vk already holds sign-extended imm when bit5=1
Qj, Qk  in  TAG_WIDTH  producer tags
qj_pend, qk_pend  in  1  operand still pending on tag
dest  in  TAG_WIDTH  result tag
cdb_in_valid, cdb_in_tag, cdb_in_data  in  1/TAG_WIDTH/DATA_WIDTH  snooped CDB
ext_req  in  N_EXT  external CDB requests
ext_tag  in  N_EXT*TAG_WIDTH  packed, requester i at [i*TAG_WIDTH +: TAG_WIDTH]
ext_data  in  N_EXT*DATA_WIDTH  packed likewise
ext_grant  out  N_EXT  one-hot grant, combinational
cdb_out_valid, cdb_out_tag, cdb_out_data  out  1/TAG_WIDTH/DATA_WIDTH  CDB drive, combinational from winner
busy_out  out  N_ENTRIES  entry occupancy

Behaviour:
- Reset (rst_n=0, async):
  - all entries not busy; ALU result register empty; RR pointer=0.
  - Outputs: busy_out=0, issue_ready=1, cdb_out_valid=0, cdb_out_tag=0, cdb_out_data=0, ext_grant=0.
- Allocation:
  - issue_valid & issue_ready writes the lowest-index free entry; busy from the next cycle.
  - issue_valid while not ready is ignored; issuer must hold.
- Same-cycle bypass: if cdb_in_valid and the pending Qj/Qk equals cdb_in_tag at issue, store cdb_in_data with pend cleared.
- Snoop: each busy entry with pend set and Q==cdb_in_tag captures cdb_in_data and clears pend on the edge.
- Age:
  - new entry age=0; on every accepted issue, all other busy entries increment age, saturating at N_ENTRIES-1.
  - ready = busy & !pend_j & !pend_k.
- Dispatch:
  - the oldest ready entry (max age; ties -> lowest index) moves to the ALU result register if that register is empty or is being granted this cycle.
  - The entry frees on the same edge. One dispatch per cycle.
  - An entry made ready by a snoop this cycle is eligible next cycle.
- ALU (combinational, registered at dispatch):
  - ADD: Vj+Vk mod 2^DATA_WIDTH.
  - AND: Vj&Vk.
  - NOT: ~Vj.
  - any other opcode: Vj.
  - Tag = entry dest.
- Arbiter:
  - requesters are index 0 = ALU result register (valid), 1..N_EXT = ext_req.
  - Round-robin starting at RR pointer; winner drives cdb_out.
  - On a grant, pointer = winner+1 mod (N_EXT+1).
  - No request -> cdb_out_valid=0, data/tag 0.
  - External requesters hold req/tag/data until granted.
- Full: with all entries busy, issue_ready=0. A dispatch frees the entry after the edge; no same-cycle reuse.
- Flush:
  - clears all entries and the ALU result register.
  - forces ext_grant=0 and cdb_out_valid=0 that cycle; pointer unchanged.
  - Issue in the flush cycle is dropped. Flush dominates dispatch and snoop.
- Reset mid-operation: immediate clear as above; no partial results survive.

Decomposition:
- lc3b_types gains:
  - an rs_entry_t struct: busy, op, Vj, Vk, Qj, Qk, pend_j, pend_k, dest, age.
  - a cdb_req_t struct: valid, tag, data.
- One sub-module: rr_cdb_arbiter (parametrised requester count; RR pointer, one-hot grant, mux).

Test Plan:
- Issue ADD Vj=0x0005, Vk=0x0003, no pend, dest=2 -> cdb_out valid tag=2 data=0x0008 two cycles after issue edge.
- Issue AND with qj_pend, Qj=5; then cdb_in tag=5 data=0x00F0, Vk=0x0FF0 -> result 0x00F0 on dest; no dispatch before the snoop.
- Fill 4 entries all pending, issue_ready=0; CDB wakes entries 3 and 1 together -> entry issued earliest dispatches first.
- ALU result pending plus ext_req[0] for 3 cycles -> grants alternate ALU, ext, ALU; external data 0x1234 tag=6 appears on its grant cycle.
- Issue with Qk=4 pending while cdb_in tag=4 data=0xAAAA in the same cycle -> entry ready next cycle, Vk=0xAAAA.
- Flush with 3 busy entries and a held result -> busy_out=0, cdb_out_valid=0 next cycle. Assert rst_n=0 mid-dispatch -> all outputs at reset values immediately.
